// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: inter-stage pipeline register with a 2-entry skid buffer.
// Carries NCH payload channels of WIDTH bits as one flat bus; channel k is
// data[k*WIDTH +: WIDTH]. Flush and reset both leave the stage empty with
// an all-zero payload, which downstream treats as a bubble (NOP).
//
// Handshake: a transfer happens on a rising clk edge when valid and ready
// are both 1 on that side (in_fire / out_fire). in_ready comes straight
// from the state register, so out_ready never reaches upstream through
// logic. out_data is stable while out_valid=1 and out_ready=0, unless a
// flush or reset is applied.
//
// The state encoding equals the number of live entries, so occupancy
// also serves as the FSM state for observation.
module pipe_stage_skid #(
  parameter int WIDTH = 32,
  parameter int NCH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [1:0]           occupancy
);

  localparam int DW = NCH * WIDTH;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   main_q, main_d;
  logic [DW-1:0]   skid_q, skid_d;
  logic            in_fire, out_fire;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // State and storage registers; reset clears everything to a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next state and storage: flush overrides the handshake. in_data is only
  // copied on in_fire, so junk on an idle input never lands in storage.
  // Unused registers are zeroed so skid is zero outside FULL and main is
  // zero in EMPTY.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (out_fire && in_fire) begin
            main_d = in_data;
          end else if (out_fire) begin
            main_d  = '0;
            state_d = EMPTY;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = FULL;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

endmodule
